vc_input_buffer_param: RTL and testbench

Parametrised router input-port buffer, the next generation of the fixed 2-VC/4-deep input buffer. Stores incoming flits in NUM_VC independent circular FIFOs. Tracks per-VC packet state with an explicit state machine and arbitrates round-robin toward route computation/VC allocation (RC/VA) and toward the switch allocator (SA). Returns one upstream credit per dequeued flit and flags overflow. Sits between the link receiver and the RC/VA/SA/crossbar stages of each router port.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/vc_fifo.sv | 63 ++++++
 rtl/vc_input_buffer_param.sv | 174 +++++++++++++++++
 tb/tb_vc_input_buffer_param.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encoding, header field positions and the
// per-VC packet state encoding used by the router input stage.
package noc_pkg;

  localparam int unsigned FLIT_TYPE_LSB = 55;
  localparam int unsigned FLIT_TYPE_W   = 3;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD     = 3'b000;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY     = 3'b001;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL     = 3'b010;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEADTAIL = 3'b011;

  localparam int unsigned PKT_ID_LSB = 48;
  localparam int unsigned PKT_ID_MSB = 54;

  typedef enum logic [1:0] {
    VcIdle,
    VcWaitVa,
    VcActive
  } vc_state_e;

  // A packet ends on either a TAIL or a single-flit HEADTAIL.
  function automatic logic is_last_flit(input logic [FLIT_TYPE_W-1:0] flit_type);
    return (flit_type == FLIT_TAIL) || (flit_type == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Circular per-VC flit FIFO with head/tail pointers, occupancy count and a
// fall-through head output. DEPTH need not be a power of two.
module vc_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_ok;
  logic             rd_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign head  = mem[head_q];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[tail_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (rd_ok) begin
        head_q <= ptr_inc(head_q);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vc_input_buffer_param.sv
// Router input-port buffer: NUM_VC circular FIFOs with per-VC packet FSMs,
// round-robin selection toward RC/VA and SA, credit return and overflow flag.
module vc_input_buffer_param
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W   = 64,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TYPE_LSB = FLIT_TYPE_LSB,
  localparam int unsigned VC_W    = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  output logic [NUM_VC-1:0] vc_ready,
  input  logic [NUM_VC-1:0] va_grant,
  output logic [FLIT_W-1:0] rc_flit,
  output logic              rc_valid,
  output logic [VC_W-1:0]   rc_vc,
  output logic              sa_request,
  input  logic              sa_grant,
  output logic [FLIT_W-1:0] sa_flit,
  output logic [VC_W-1:0]   sa_vc,
  output logic              sa_valid,
  output logic              credit_valid,
  output logic [VC_W-1:0]   credit_vc,
  output logic              overflow_err
);

  vc_state_e         state_q [NUM_VC];
  logic [VC_W-1:0]   rc_ptr_q;
  logic [VC_W-1:0]   sa_ptr_q;
  logic              credit_valid_q;
  logic [VC_W-1:0]   credit_vc_q;
  logic              overflow_q;

  logic [FLIT_W-1:0] head_flit [NUM_VC];
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] rd_en;
  logic [NUM_VC-1:0] wait_va;
  logic [NUM_VC-1:0] sa_cand;
  logic [NUM_VC-1:0] va_acc;

  logic              vc_ok;
  logic              hit_full;
  logic              ovf_set;
  logic              deq;
  logic              sa_last;
  logic              rc_found;
  logic [VC_W-1:0]   rc_sel;
  logic              sa_found;
  logic [VC_W-1:0]   sa_sel;
  logic [VC_W-1:0]   rc_idx;
  logic [VC_W-1:0]   sa_idx;
  logic [VC_W-1:0]   va_low;

  assign vc_ok = (32'(in_vc) < NUM_VC);
  assign deq   = sa_grant && sa_found;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_en[v]    = in_valid && vc_ok && (in_vc == VC_W'(v)) && !full[v];
    assign rd_en[v]    = deq && (sa_sel == VC_W'(v));
    assign wait_va[v]  = (state_q[v] == VcWaitVa);
    assign sa_cand[v]  = (state_q[v] == VcActive) && !empty[v];
    assign va_acc[v]   = va_grant[v] && wait_va[v];
    assign vc_ready[v] = !full[v];

    vc_fifo #(
      .W     (FLIT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[v]),
      .wr_data (in_flit),
      .rd_en   (rd_en[v]),
      .head    (head_flit[v]),
      .full    (full[v]),
      .empty   (empty[v])
    );
  end

  always_comb begin
    hit_full = 1'b0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (in_vc == VC_W'(v)) begin
        hit_full = full[v];
      end
    end
    ovf_set = in_valid && (!vc_ok || hit_full);
  end

  // Round-robin: scan from the pointer and take the first eligible VC.
  always_comb begin
    rc_found = 1'b0;
    rc_sel   = '0;
    rc_idx   = '0;
    sa_found = 1'b0;
    sa_sel   = '0;
    sa_idx   = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      rc_idx = VC_W'((32'(rc_ptr_q) + i) % NUM_VC);
      if (!rc_found && wait_va[rc_idx]) begin
        rc_found = 1'b1;
        rc_sel   = rc_idx;
      end
      sa_idx = VC_W'((32'(sa_ptr_q) + i) % NUM_VC);
      if (!sa_found && sa_cand[sa_idx]) begin
        sa_found = 1'b1;
        sa_sel   = sa_idx;
      end
    end
  end

  // Multiple simultaneous grants: the pointer follows the lowest one.
  always_comb begin
    va_low = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (va_acc[i]) begin
        va_low = VC_W'(i);
      end
    end
  end

  assign rc_valid   = rc_found;
  assign rc_vc      = rc_found ? rc_sel : '0;
  assign rc_flit    = rc_found ? head_flit[rc_sel] : '0;
  assign sa_request = sa_found;
  assign sa_valid   = sa_found;
  assign sa_vc      = sa_found ? sa_sel : '0;
  assign sa_flit    = sa_found ? head_flit[sa_sel] : '0;
  assign sa_last    = is_last_flit(sa_flit[TYPE_LSB +: FLIT_TYPE_W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        state_q[v] <= VcIdle;
      end
      rc_ptr_q       <= '0;
      sa_ptr_q       <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        case (state_q[v])
          // A flit written this cycle already makes the VC non-empty.
          VcIdle:   if (!empty[v] || wr_en[v]) state_q[v] <= VcWaitVa;
          VcWaitVa: if (va_grant[v]) state_q[v] <= VcActive;
          VcActive: if (rd_en[v] && sa_last) state_q[v] <= VcIdle;
          default:  state_q[v] <= VcIdle;
        endcase
      end
      if (|va_acc) begin
        rc_ptr_q <= (va_low == VC_W'(NUM_VC - 1)) ? '0 : va_low + 1'b1;
      end
      if (deq) begin
        sa_ptr_q <= (sa_sel == VC_W'(NUM_VC - 1)) ? '0 : sa_sel + 1'b1;
      end
      credit_valid_q <= deq;
      credit_vc_q    <= deq ? sa_sel : '0;
      overflow_q     <= overflow_q || ovf_set;
    end
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_vc_input_buffer_param.sv
// Directed bench for vc_input_buffer_param (2 VCs, depth 4): packet flow,
// overflow, round-robin SA, single-flit packets and mid-packet reset.
module tb_vc_input_buffer_param;
  import noc_pkg::*;

  localparam int unsigned FLIT_W = 64;
  localparam int unsigned NUM_VC = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned VC_W   = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLIT_W-1:0] in_flit = '0;
  logic              in_valid = 1'b0;
  logic [VC_W-1:0]   in_vc = '0;
  logic [NUM_VC-1:0] vc_ready;
  logic [NUM_VC-1:0] va_grant = '0;
  logic [FLIT_W-1:0] rc_flit;
  logic              rc_valid;
  logic [VC_W-1:0]   rc_vc;
  logic              sa_request;
  logic              sa_grant = 1'b0;
  logic [FLIT_W-1:0] sa_flit;
  logic [VC_W-1:0]   sa_vc;
  logic              sa_valid;
  logic              credit_valid;
  logic [VC_W-1:0]   credit_vc;
  logic              overflow_err;

  int checks = 0;
  int errors = 0;
  int ncred;

  vc_input_buffer_param #(
    .FLIT_W   (FLIT_W),
    .NUM_VC   (NUM_VC),
    .DEPTH    (DEPTH),
    .TYPE_LSB (55)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .vc_ready     (vc_ready),
    .va_grant     (va_grant),
    .rc_flit      (rc_flit),
    .rc_valid     (rc_valid),
    .rc_vc        (rc_vc),
    .sa_request   (sa_request),
    .sa_grant     (sa_grant),
    .sa_flit      (sa_flit),
    .sa_vc        (sa_vc),
    .sa_valid     (sa_valid),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [2:0] t, input logic [7:0] id);
    logic [FLIT_W-1:0] f;
    f          = '0;
    f[7:0]     = id;
    f[63:58]   = id[5:0];
    f[57:55]   = t;
    return f;
  endfunction

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [VC_W-1:0] vc, input logic [2:0] t, input logic [7:0] id);
    in_valid = 1'b1;
    in_vc    = vc;
    in_flit  = mk(t, id);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_flit  = '0;
    in_vc    = '0;
  endtask

  initial begin
    // Reset values
    tick();
    #1;
    check("rst_vc_ready", 64'(vc_ready), 64'h3);
    check("rst_rc_valid", 64'(rc_valid), 64'h0);
    check("rst_sa_valid", 64'(sa_valid), 64'h0);
    check("rst_rc_flit", rc_flit, 64'h0);
    check("rst_credit", 64'(credit_valid), 64'h0);
    check("rst_ovf", 64'(overflow_err), 64'h0);
    tick();
    rst = 1'b0;

    // Test 1: HEAD/BODY/TAIL on VC0
    wr(0, FLIT_HEAD, 8'h11);
    tick();
    wr(0, FLIT_BODY, 8'h12);
    #1;
    check("t1_rc_valid_c1", 64'(rc_valid), 64'h1);
    check("t1_rc_vc_c1", 64'(rc_vc), 64'h0);
    check("t1_rc_flit_c1", rc_flit, mk(FLIT_HEAD, 8'h11));
    check("t1_sa_valid_c1", 64'(sa_valid), 64'h0);
    tick();
    wr(0, FLIT_TAIL, 8'h13);
    va_grant = 2'b01;
    #1;
    check("t1_sa_valid_c2", 64'(sa_valid), 64'h0);
    tick();
    idle_in();
    va_grant = 2'b00;
    sa_grant = 1'b1;
    #1;
    check("t1_sa_valid_c3", 64'(sa_valid), 64'h1);
    check("t1_sa_flit_c3", sa_flit, mk(FLIT_HEAD, 8'h11));
    check("t1_rc_valid_c3", 64'(rc_valid), 64'h0);
    check("t1_credit_c3", 64'(credit_valid), 64'h0);
    tick();
    #1;
    check("t1_credit_c4", 64'({credit_valid, credit_vc}), 64'h2);
    check("t1_sa_flit_c4", sa_flit, mk(FLIT_BODY, 8'h12));
    tick();
    #1;
    check("t1_credit_c5", 64'({credit_valid, credit_vc}), 64'h2);
    check("t1_sa_flit_c5", sa_flit, mk(FLIT_TAIL, 8'h13));
    tick();
    #1;
    check("t1_credit_c6", 64'({credit_valid, credit_vc}), 64'h2);
    check("t1_sa_valid_c6", 64'(sa_valid), 64'h0);
    sa_grant = 1'b0;
    tick();
    #1;
    check("t1_credit_c7", 64'(credit_valid), 64'h0);
    check("t1_rc_valid_c7", 64'(rc_valid), 64'h0);
    check("t1_vc_ready_c7", 64'(vc_ready), 64'h3);

    // Test 2: five writes to VC1, no grants
    wr(1, FLIT_HEAD, 8'h21);
    tick();
    wr(1, FLIT_BODY, 8'h22);
    tick();
    wr(1, FLIT_BODY, 8'h23);
    tick();
    wr(1, FLIT_TAIL, 8'h24);
    tick();
    wr(1, FLIT_BODY, 8'h25);
    #1;
    check("t2_vc_ready_4", 64'(vc_ready), 64'h1);
    check("t2_ovf_before", 64'(overflow_err), 64'h0);
    check("t2_rc_vc", 64'({rc_valid, rc_vc}), 64'h3);
    tick();
    idle_in();
    #1;
    check("t2_ovf_after", 64'(overflow_err), 64'h1);
    check("t2_vc_ready_5", 64'(vc_ready), 64'h1);
    va_grant = 2'b10;
    tick();
    va_grant = 2'b00;
    sa_grant = 1'b1;
    ncred = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (credit_valid) ncred++;
    end
    sa_grant = 1'b0;
    #1;
    check("t2_credits", 64'(ncred), 64'd4);
    check("t2_rc_valid_end", 64'(rc_valid), 64'h0);
    check("t2_vc_ready_end", 64'(vc_ready), 64'h3);

    // Test 3: both VCs active, two flits each
    wr(0, FLIT_HEAD, 8'h30);
    tick();
    wr(0, FLIT_TAIL, 8'h31);
    tick();
    wr(1, FLIT_HEAD, 8'h40);
    tick();
    wr(1, FLIT_TAIL, 8'h41);
    tick();
    idle_in();
    #1;
    check("t3_rc_sel", 64'({rc_valid, rc_vc}), 64'h2);
    va_grant = 2'b11;
    tick();
    va_grant = 2'b00;
    sa_grant = 1'b1;
    ncred    = 0;
    #1;
    check("t3_sa_vc_0", 64'(sa_vc), 64'h0);
    check("t3_sa_flit_0", sa_flit, mk(FLIT_HEAD, 8'h30));
    tick();
    if (credit_valid) ncred++;
    #1;
    check("t3_sa_vc_1", 64'(sa_vc), 64'h1);
    check("t3_sa_flit_1", sa_flit, mk(FLIT_HEAD, 8'h40));
    tick();
    if (credit_valid) ncred++;
    #1;
    check("t3_sa_vc_2", 64'(sa_vc), 64'h0);
    check("t3_sa_flit_2", sa_flit, mk(FLIT_TAIL, 8'h31));
    tick();
    if (credit_valid) ncred++;
    #1;
    check("t3_sa_vc_3", 64'(sa_vc), 64'h1);
    check("t3_sa_flit_3", sa_flit, mk(FLIT_TAIL, 8'h41));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (credit_valid) ncred++;
    end
    sa_grant = 1'b0;
    check("t3_credits", 64'(ncred), 64'd4);

    // Test 4: single-flit HEADTAIL packet
    wr(0, FLIT_HEADTAIL, 8'h50);
    tick();
    idle_in();
    #1;
    check("t4_rc_flit", rc_flit, mk(FLIT_HEADTAIL, 8'h50));
    va_grant = 2'b01;
    tick();
    va_grant = 2'b00;
    sa_grant = 1'b1;
    #1;
    check("t4_sa_sel", 64'({sa_valid, sa_vc}), 64'h2);
    tick();
    sa_grant = 1'b0;
    #1;
    check("t4_credit", 64'({credit_valid, credit_vc}), 64'h2);
    check("t4_sa_valid", 64'(sa_valid), 64'h0);
    check("t4_rc_valid", 64'(rc_valid), 64'h0);
    tick();
    #1;
    check("t4_credit_end", 64'(credit_valid), 64'h0);

    // Test 5: write to a full VC while it dequeues
    rst = 1'b1;
    #1;
    check("t5_rst_ovf", 64'(overflow_err), 64'h0);
    tick();
    rst = 1'b0;
    wr(0, FLIT_HEAD, 8'h60);
    tick();
    wr(0, FLIT_BODY, 8'h61);
    tick();
    wr(0, FLIT_BODY, 8'h62);
    tick();
    wr(0, FLIT_TAIL, 8'h63);
    tick();
    idle_in();
    va_grant = 2'b01;
    #1;
    check("t5_vc_ready_full", 64'(vc_ready), 64'h2);
    tick();
    va_grant = 2'b00;
    sa_grant = 1'b1;
    wr(0, FLIT_BODY, 8'h6f);
    #1;
    check("t5_ovf_before", 64'(overflow_err), 64'h0);
    tick();
    idle_in();
    #1;
    check("t5_ovf_after", 64'(overflow_err), 64'h1);
    check("t5_vc_ready_3", 64'(vc_ready), 64'h3);
    ncred = credit_valid ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (credit_valid) ncred++;
    end
    sa_grant = 1'b0;
    #1;
    check("t5_credits", 64'(ncred), 64'd4);
    check("t5_rc_valid_end", 64'(rc_valid), 64'h0);
    check("t5_sa_valid_end", 64'(sa_valid), 64'h0);

    // Test 6: reset mid-packet
    wr(0, FLIT_HEAD, 8'h70);
    tick();
    wr(0, FLIT_BODY, 8'h71);
    tick();
    wr(0, FLIT_TAIL, 8'h72);
    tick();
    idle_in();
    va_grant = 2'b01;
    tick();
    va_grant = 2'b00;
    sa_grant = 1'b1;
    tick();
    tick();
    sa_grant = 1'b0;
    #1;
    check("t6_pre_credit", 64'(credit_valid), 64'h1);
    check("t6_pre_sa_flit", sa_flit, mk(FLIT_TAIL, 8'h72));
    #1;
    rst = 1'b1;
    #1;
    check("t6_vc_ready", 64'(vc_ready), 64'h3);
    check("t6_rc_valid", 64'(rc_valid), 64'h0);
    check("t6_sa_valid", 64'({sa_valid, sa_request}), 64'h0);
    check("t6_sa_flit", sa_flit, 64'h0);
    check("t6_credit", 64'({credit_valid, credit_vc}), 64'h0);
    check("t6_ovf", 64'(overflow_err), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("t6_post_rc_valid", 64'(rc_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
